rambus_sram_responder: RTL

Wishbone classic-cycle responder that services the shared-RAM bus (rambus) driven by a project's RAM master and converts each request into a single access on one read/write port of an OpenRAM-style SRAM macro. It sits between the rambus master port and the macro's port 0. It sequences chip-select, write-enable, byte mask, address and data, waits out the macro's read latency, and returns a single-cycle ack.

---
 rtl/rambus_sram_responder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/rambus_sram_responder.sv
// rambus_sram_responder
// Wishbone classic-cycle responder that turns each rambus request into one
// access on port 0 of an OpenRAM-style single-port SRAM macro. All outputs
// are registered. A request is accepted in IDLE, the SRAM port is active for
// exactly one cycle (ACCESS), reads then wait out the macro latency (WAIT),
// and a single-cycle ack closes the transaction (ACK).
//
// Handshake: a request is stb_i & cyc_i sampled while IDLE; the request
// fields are latched at acceptance and later bus changes are ignored. ack_o
// is high for exactly one cycle per completed transaction and dat_o is valid
// while ack_o is high. Dropping cyc_i in ACCESS or WAIT aborts the transaction
// without an ack.
module rambus_sram_responder #(
    parameter int WORD_ADDR_W  = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic                   rambus_wb_stb_i,
    input  logic                   rambus_wb_cyc_i,
    input  logic                   rambus_wb_we_i,
    input  logic [3:0]             rambus_wb_sel_i,
    input  logic [31:0]            rambus_wb_dat_i,
    input  logic [9:0]             rambus_wb_adr_i,
    output logic                   rambus_wb_ack_o,
    output logic [31:0]            rambus_wb_dat_o,
    output logic                   ram_csb0_o,
    output logic                   ram_web0_o,
    output logic [3:0]             ram_wmask0_o,
    output logic [WORD_ADDR_W-1:0] ram_addr0_o,
    output logic [31:0]            ram_din0_o,
    input  logic [31:0]            ram_dout0_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic                   ack_q, ack_d;
    logic [31:0]            dat_q, dat_d;
    logic                   csb_q, csb_d;
    logic                   web_q, web_d;
    logic [3:0]             wmask_q, wmask_d;
    logic [WORD_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]            din_q, din_d;

    // Byte-offset bits and any bits above the word address are don't-care.
    logic unused_adr;
    assign unused_adr = ^rambus_wb_adr_i;

    // Register every piece of state and every output; reset is asynchronous.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= 32'd0;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            wmask_q <= 4'd0;
            addr_q  <= '0;
            din_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    // Next-state and next-output logic; the SRAM port idles unless accepting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        ack_d   = 1'b0;
        dat_d   = dat_q;
        csb_d   = 1'b1;
        web_d   = 1'b1;
        wmask_d = 4'd0;
        addr_d  = addr_q;
        din_d   = din_q;
        case (state_q)
            IDLE: begin
                if (rambus_wb_stb_i && rambus_wb_cyc_i) begin
                    state_d = ACCESS;
                    we_d    = rambus_wb_we_i;
                    csb_d   = 1'b0;
                    web_d   = ~rambus_wb_we_i;
                    wmask_d = rambus_wb_we_i ? rambus_wb_sel_i : 4'd0;
                    addr_d  = rambus_wb_adr_i[WORD_ADDR_W+1:2];
                    din_d   = rambus_wb_dat_i;
                end
            end
            ACCESS: begin
                // The macro samples the port at the end of this cycle no
                // matter what; an abort only suppresses the ack.
                if (!rambus_wb_cyc_i) begin
                    state_d = IDLE;
                end else if (we_q) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 2'(READ_LATENCY - 1);
                end
            end
            WAIT: begin
                if (!rambus_wb_cyc_i) begin
                    state_d = IDLE;
                    cnt_d   = 2'd0;
                end else if (cnt_q == 2'd0) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    dat_d   = ram_dout0_i;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rambus_wb_ack_o = ack_q;
    assign rambus_wb_dat_o = dat_q;
    assign ram_csb0_o      = csb_q;
    assign ram_web0_o      = web_q;
    assign ram_wmask0_o    = wmask_q;
    assign ram_addr0_o     = addr_q;
    assign ram_din0_o      = din_q;

endmodule
